mipi_img_pack32: RTL

- Downstream of the CSI-2 deserializer, in the img_clk domain. Consumes its pixel stream (pixel data, data valid, line valid, frame valid).
- Packs pixels into 32-bit words with start-of-frame and end-of-line tags.
- Buffers words in a small FIFO so a memory writer can apply backpressure.
- The pixel source cannot stall, so a full FIFO drops words and sets a sticky overflow flag.

---
 rtl/mipi_img_pack32_pkg.sv | 26 ++
 rtl/mipi_img_pack32_if.sv | 29 ++
 rtl/mipi_img_pack32_fifo.sv | 68 ++++++
 rtl/mipi_img_pack32.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_img_pack32_pkg.sv
// Shared constants for the 32-bit pixel packer: pixel modes and the layout
// of one output FIFO entry (packed word plus its frame/line tags).
package mipi_pack_pkg;

    localparam logic MODE_8  = 1'b0;
    localparam logic MODE_16 = 1'b1;

    localparam int ENTRY_W        = 34;
    localparam int ENTRY_WORD_LSB = 0;
    localparam int ENTRY_WORD_W   = 32;
    localparam int ENTRY_EOL_BIT  = 32;
    localparam int ENTRY_SOF_BIT  = 33;

    typedef logic [ENTRY_W-1:0] entry_t;

    function automatic entry_t make_entry(input logic sof, input logic eol,
                                          input logic [31:0] word);
        entry_t e;
        e = '0;
        e[ENTRY_WORD_LSB +: ENTRY_WORD_W] = word;
        e[ENTRY_EOL_BIT]                  = eol;
        e[ENTRY_SOF_BIT]                  = sof;
        return e;
    endfunction

endpackage

// File: rtl/mipi_img_pack32_if.sv
// Pixel stream from the CSI-2 deserializer and packed-word stream to the
// memory writer, each bundled with source (master) and sink (slave) views.

// The pixel stream has no backpressure: dvi qualifies dati while lvi/fvi frame it.
interface mipi_pix_if #(
    parameter int DATA_WIDTH = 10
);
    logic [DATA_WIDTH-1:0] dati;
    logic                  dvi;
    logic                  lvi;
    logic                  fvi;

    modport master(output dati, dvi, lvi, fvi);
    modport slave (input  dati, dvi, lvi, fvi);
endinterface

// A word transfers on a cycle where word_valid && word_ready; word, word_sof and
// word_eol are stable while word_valid is high and not yet accepted, and
// word_valid never depends combinationally on word_ready.
interface mipi_word_if;
    logic [31:0] word;
    logic        word_sof;
    logic        word_eol;
    logic        word_valid;
    logic        word_ready;

    modport master(output word, word_sof, word_eol, word_valid, input word_ready);
    modport slave (input  word, word_sof, word_eol, word_valid, output word_ready);
endinterface

// File: rtl/mipi_img_pack32_fifo.sv
// Output FIFO for packed words: up to two pushes and one pop per cycle.
// Slot 0 is always written before slot 1 and a same-cycle pop frees a slot.
module mipi_pack_fifo
    import mipi_pack_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush_i,
    input  logic   push0_i,
    input  entry_t din0_i,
    input  logic   push1_i,
    input  entry_t din1_i,
    input  logic   pop_i,
    output entry_t dout_o,
    output logic   empty_o,
    output logic   drop_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, wr1;
    logic [AW:0]   cnt_q, cnt_d, free, n_push;
    logic          full, do_pop, acc0, acc1;

    assign empty_o = (cnt_q == '0);
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        full   = (cnt_q == DEPTH_C);
        do_pop = pop_i && !empty_o && !flush_i;
        free   = DEPTH_C - cnt_q + (AW+1)'(do_pop);
        acc0   = !flush_i && push0_i && (!full || do_pop);
        // The second push needs a slot beyond the one the first push took.
        acc1   = !flush_i && push1_i && (free > (AW+1)'(acc0));
        n_push = (AW+1)'(acc0) + (AW+1)'(acc1);
        wr1    = acc0 ? wr_q + AW'(1) : wr_q;
        drop_o = !flush_i && ((push0_i && !acc0) || (push1_i && !acc1));
        wr_d   = wr_q + n_push[AW-1:0];
        rd_d   = rd_q + AW'(do_pop);
        cnt_d  = cnt_q + n_push - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc0) mem_q[wr_q] <= din0_i;
        if (acc1) mem_q[wr1]  <= din1_i;
    end

endmodule

// File: rtl/mipi_img_pack32.sv
// Packs CSI-2 pixels into tagged 32-bit words and buffers them for a memory writer.
// Define MIPI_PACK_LINE_CHECK_EN to build the line-length consistency checker.
module mipi_img_pack32
    import mipi_pack_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        img_clk,
    input  logic        resetb,
    input  logic        enable,
    input  logic        mode,
    mipi_pix_if.slave   pix,
    mipi_word_if.master wout,
    output logic        overflow,
    output logic [15:0] line_cnt,
    output logic [15:0] line_pix,
    output logic        line_len_err
);

    logic [DATA_WIDTH-1:0] dati;
    logic [15:0]           pix16;

    logic [1:0]  lane_q, lane_d;
    logic [31:0] acc_q, acc_d, pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        sof_pend_q, sof_pend_d;
    logic        armed_q, armed_d;
    logic        overflow_q, overflow_d;
    logic        lvi_q, fvi_q, mode_q;
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic [15:0] line_pix_q, line_pix_d;

    logic        fvi_rise, fvi_fall, frame_act, eff_lvi, line_end, accept, last_lane;
    logic [31:0] filled, w0;
    logic        p0, p1, e0;

    entry_t      fifo_dout;
    logic        fifo_empty, fifo_drop;

    assign dati  = pix.dati;
    assign pix16 = 16'(dati);

    always_comb begin
        fvi_rise  = enable && pix.fvi && !fvi_q;
        fvi_fall  = fvi_q && !pix.fvi;
        // Pixels only count inside a frame whose rising edge we saw while enabled.
        frame_act = enable && pix.fvi && (armed_q || fvi_rise);
        eff_lvi   = frame_act && pix.lvi;
        line_end  = enable && lvi_q && !eff_lvi;
        accept    = eff_lvi && pix.dvi;
        last_lane = (mode_q == MODE_16) ? (lane_q == 2'd1) : (lane_q == 2'd3);

        filled = (lane_q == 2'd0) ? 32'd0 : acc_q;
        if (mode_q == MODE_16) begin
            if (lane_q[0]) filled[31:16] = pix16;
            else           filled[15:0]  = pix16;
        end else begin
            case (lane_q)
                2'd0:    filled[7:0]   = pix16[7:0];
                2'd1:    filled[15:8]  = pix16[7:0];
                2'd2:    filled[23:16] = pix16[7:0];
                default: filled[31:24] = pix16[7:0];
            endcase
        end
    end

    always_comb begin
        lane_d     = lane_q;
        acc_d      = acc_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        sof_pend_d = sof_pend_q;
        overflow_d = overflow_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        line_pix_d = line_pix_q;
        armed_d    = armed_q;
        p0         = 1'b0;
        p1         = 1'b0;
        w0         = pend_q;
        e0         = 1'b0;

        if (accept) begin
            if (pix_cnt_q != 16'hFFFF) pix_cnt_d = pix_cnt_q + 16'd1;
            p0 = pend_vld_q;
            if (last_lane) begin
                pend_d     = filled;
                pend_vld_d = 1'b1;
                lane_d     = 2'd0;
                acc_d      = 32'd0;
            end else begin
                acc_d      = filled;
                lane_d     = lane_q + 2'd1;
                pend_vld_d = 1'b0;
            end
        end else if (line_end) begin
            if (line_cnt_q != 16'hFFFF) line_cnt_d = line_cnt_q + 16'd1;
            line_pix_d = pix_cnt_q;
            pix_cnt_d  = 16'd0;
            // Pending word goes first; a partial word, if any, closes the line.
            if (pend_vld_q) begin
                p0 = 1'b1;
                e0 = (lane_q == 2'd0);
                p1 = (lane_q != 2'd0);
            end else if (lane_q != 2'd0) begin
                p0 = 1'b1;
                w0 = acc_q;
                e0 = 1'b1;
            end
            lane_d     = 2'd0;
            acc_d      = 32'd0;
            pend_vld_d = 1'b0;
        end

        if (p0)        sof_pend_d = 1'b0;
        if (fvi_fall)  sof_pend_d = 1'b0;
        if (fifo_drop) overflow_d = 1'b1;

        if (fvi_rise) begin
            sof_pend_d = 1'b1;
            line_cnt_d = 16'd0;
            overflow_d = 1'b0;
            armed_d    = 1'b1;
        end else if (!pix.fvi) begin
            armed_d = 1'b0;
        end

        if (!enable) begin
            lane_d     = 2'd0;
            acc_d      = 32'd0;
            pend_vld_d = 1'b0;
            sof_pend_d = 1'b0;
            overflow_d = 1'b0;
            pix_cnt_d  = 16'd0;
            armed_d    = 1'b0;
        end
    end

    always_ff @(posedge img_clk or negedge resetb) begin
        if (!resetb) begin
            lane_q     <= 2'd0;
            acc_q      <= 32'd0;
            pend_q     <= 32'd0;
            pend_vld_q <= 1'b0;
            sof_pend_q <= 1'b0;
            armed_q    <= 1'b0;
            overflow_q <= 1'b0;
            lvi_q      <= 1'b0;
            fvi_q      <= 1'b0;
            mode_q     <= MODE_8;
            pix_cnt_q  <= 16'd0;
            line_cnt_q <= 16'd0;
            line_pix_q <= 16'd0;
        end else begin
            lane_q     <= lane_d;
            acc_q      <= acc_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sof_pend_q <= sof_pend_d;
            armed_q    <= armed_d;
            overflow_q <= overflow_d;
            lvi_q      <= eff_lvi;
            fvi_q      <= pix.fvi;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            line_pix_q <= line_pix_d;
            if (!pix.lvi) mode_q <= mode;
        end
    end

    mipi_pack_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (img_clk),
        .rst_n   (resetb),
        .flush_i (!enable),
        .push0_i (p0),
        .din0_i  (make_entry(sof_pend_q, e0, w0)),
        .push1_i (p1),
        .din1_i  (make_entry(1'b0, 1'b1, acc_q)),
        .pop_i   (wout.word_ready),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign wout.word       = fifo_dout[ENTRY_WORD_LSB +: ENTRY_WORD_W];
    assign wout.word_eol   = fifo_dout[ENTRY_EOL_BIT];
    assign wout.word_sof   = fifo_dout[ENTRY_SOF_BIT];
    assign wout.word_valid = !fifo_empty;

    assign overflow = overflow_q;
    assign line_cnt = line_cnt_q;
    assign line_pix = line_pix_q;

`ifdef MIPI_PACK_LINE_CHECK_EN
    logic [15:0] ref_len_q;
    logic        ref_vld_q, len_err_q;

    // The first completed line of a frame sets the length every later line must match.
    always_ff @(posedge img_clk or negedge resetb) begin
        if (!resetb) begin
            ref_len_q <= 16'd0;
            ref_vld_q <= 1'b0;
            len_err_q <= 1'b0;
        end else if (!enable || fvi_rise) begin
            ref_vld_q <= 1'b0;
            len_err_q <= 1'b0;
        end else if (line_end) begin
            if (!ref_vld_q) begin
                ref_len_q <= pix_cnt_q;
                ref_vld_q <= 1'b1;
            end else if (pix_cnt_q != ref_len_q) begin
                len_err_q <= 1'b1;
            end
        end
    end

    assign line_len_err = len_err_q;
`else
    assign line_len_err = 1'b0;
`endif

endmodule
